fpalu_addsub_pipe: RTL
======================

FPALU_ADDSUB_PIPE -- requirements
Module: fpalu_addsub_pipe

Interface
REQ-001 Parameter EXP_W, default 8: exponent field width in bits (minimum 4).
REQ-002 Parameter MAN_W, default 23: stored fraction width in bits, hidden bit excluded (minimum 4).
REQ-003 Local width W = 1+EXP_W+MAN_W shall be used for all operand and result fields, packed as {sign, exponent, fraction}; bias = 2^(EXP_W-1)-1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  operand pair and op are valid this cycle.
REQ-007 in_ready  output  1  block accepts the operand pair this cycle.
REQ-008 a_in  input  W  operand A.
REQ-009 b_in  input  W  operand B.
REQ-010 op  input  1  0 = A+B, 1 = A-B (B sign inverted before alignment).
REQ-011 out_valid  output  1  result and flags are valid.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 sum  output  W  result.
REQ-014 ovf  output  1  result overflowed to infinity.
REQ-015 unf  output  1  nonzero exact result flushed to zero.
REQ-016 inx  output  1  result inexact (bits discarded by alignment or rounding).

Function
REQ-017 Three-stage pipeline: S1 unpack/swap/align, S2 add/subtract/leading-zero count, S3 normalise/round/pack; latency 3 cycles from accepted input to out_valid with no stall.
REQ-018 Transfer in: in_valid&&in_ready; transfer out: out_valid&&out_ready.
REQ-019 Global stall: advance = !out_valid || out_ready; in_ready = advance; on !advance every stage register holds its value; sum and flags stay stable while out_valid&&!out_ready.
REQ-020 Throughput one result per cycle while out_ready is high; bubbles propagate as per-stage valid=0.
REQ-021 S1: larger-magnitude operand (exponent, then fraction) becomes A; B significand shifted right by exponent difference with guard, round and sticky bits retained; difference >= MAN_W+3 collapses B to sticky only.
REQ-022 S2: effective add when signs equal, otherwise subtract smaller magnitude from larger; result sign is sign of larger-magnitude operand; exact zero difference yields +0.
REQ-023 S3: carry-out shifts right 1 and increments exponent; otherwise left shift by leading-zero count and decrement exponent.
REQ-024 Exponent field 0 on input is treated as zero (denormals flushed, sign kept); normalised exponent <= 0 with nonzero significand gives signed zero with unf=1.
REQ-025 Exponent reaching 2^EXP_W-1 after normalise/round gives signed infinity with ovf=1 and inx=1.
REQ-026 Specials: any NaN input, or inf + (-inf) effective, gives canonical quiet NaN {0, all-ones exp, MSB fraction 1}; inf with finite gives that inf; no flags set for specials.
REQ-027 x + (-x) of equal nonzero magnitude yields +0x0, inx=0.

Reset
REQ-028 While rst is high at a clock edge: all stage valids, out_valid, sum, ovf, unf, inx cleared to 0; in_ready = 1 in the cycle after reset.
REQ-029 Reset mid-operation discards all in-flight results; no result in flight at reset shall ever appear on out_valid.

Configuration
REQ-030 Macro FPALU_ADDSUB_RNE_EN defined: S3 rounds to nearest, ties-to-even, using guard/round/sticky; mantissa carry from rounding renormalises and may overflow per REQ-025.
REQ-031 FPALU_ADDSUB_RNE_EN undefined: S3 truncates toward zero; inx still reports discarded bits; latency unchanged.

Verification (defaults EXP_W=8, MAN_W=23)
REQ-032 a=0x3F800000, b=0x3F800000, op=0 -> sum=0x40000000, flags 0, out_valid exactly 3 cycles after accept.
REQ-033 a=0x40400000, b=0x3F800000, op=1 -> sum=0x40000000; a=0x3FC00000, b=0xBFC00000, op=0 -> sum=0x00000000.
REQ-034 a=b=0x7F7FFFFF, op=0 -> sum=0x7F800000, ovf=1, inx=1; a=0x7F800000, b=0xFF800000, op=0 -> sum=0x7FC00000.
REQ-035 a=0x3F800001, b=0x33800000, op=0 -> RNE: 0x3F800002, inx=1; truncate: 0x3F800001, inx=1; a=0x3F800000, same b -> RNE 0x3F800000 (tie to even).
REQ-036 Back-to-back 8 random pairs, out_ready low 5 cycles mid-stream -> sum held stable, no loss/duplication, in order, matching reference model.
REQ-037 rst asserted 1 cycle with 2 results in flight -> no out_valid for those; next accepted pair returns correctly 3 cycles later.

Source files
------------

// File: rtl/fpalu_addsub_pipe_if.sv
// Handshake and operand/result bus for the fpalu_addsub_pipe adder.
// master: the side that supplies operands and consumes results.
// slave:  the adder itself.
interface fpalu_addsub_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         ovf;
  logic         unf;
  logic         inx;

  modport master (
    output in_valid, a_in, b_in, op, out_ready,
    input  in_ready, out_valid, sum, ovf, unf, inx
  );

  modport slave (
    input  in_valid, a_in, b_in, op, out_ready,
    output in_ready, out_valid, sum, ovf, unf, inx
  );
endinterface

// File: rtl/fpalu_addsub_pipe.sv
// Three-stage floating-point add/subtract pipeline.
//   S1 unpack, order by magnitude, align smaller operand (guard/round/sticky kept)
//   S2 add or subtract significands, count leading zeros
//   S3 normalise, round, pack, raise ovf/unf/inx
// Denormal inputs are flushed to zero. A single global stall freezes every
// stage while a result waits on out_ready.
// Optional feature: define FPALU_ADDSUB_RNE_EN for round-to-nearest-even;
// without it S3 truncates toward zero.
module fpalu_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic                clk,
  input logic                rst,
  fpalu_addsub_pipe_if.slave bus
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int SW  = MAN_W + 4;                      // hidden + fraction + G/R/S
  localparam int LZW = $clog2(MAN_W + 5);
  localparam int EW  = ((EXP_W > LZW) ? EXP_W : LZW) + 2; // room for sign and carry
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [W-1:0]     QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic advance;
  logic out_valid_q;

  assign advance      = !out_valid_q || bus.out_ready;
  assign bus.in_ready = advance;

  // ---------------- S1: unpack / swap / align ----------------
  logic             a_sign, b_sign_raw, b_sign;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_frac, b_frac;

  assign {a_sign, a_exp, a_frac}     = bus.a_in;
  assign {b_sign_raw, b_exp, b_frac} = bus.b_in;
  assign b_sign = b_sign_raw ^ bus.op;

  logic             a_nan, b_nan, a_inf, b_inf;
  logic [MAN_W:0]   a_sig, b_sig, l_sig, s_sig;
  logic [EXP_W-1:0] l_exp, s_exp, exp_diff;
  logic             swap, l_sign;
  logic [SW-1:0]    s_ext, s_al;
  logic             spec;
  logic [W-1:0]     spec_val;

  // Classify operands, pick the larger magnitude and shift the smaller into place.
  always_comb begin
    a_nan = (a_exp == EXP_MAX) && (a_frac != '0);
    b_nan = (b_exp == EXP_MAX) && (b_frac != '0);
    a_inf = (a_exp == EXP_MAX) && (a_frac == '0);
    b_inf = (b_exp == EXP_MAX) && (b_frac == '0);
    a_sig = (a_exp == '0) ? '0 : {1'b1, a_frac};
    b_sig = (b_exp == '0) ? '0 : {1'b1, b_frac};

    swap   = {b_exp, b_sig} > {a_exp, a_sig};
    l_sign = swap ? b_sign : a_sign;
    l_exp  = swap ? b_exp  : a_exp;
    l_sig  = swap ? b_sig  : a_sig;
    s_exp  = swap ? a_exp  : b_exp;
    s_sig  = swap ? a_sig  : b_sig;

    exp_diff = l_exp - s_exp;
    s_ext    = {s_sig, 3'b000};
    if (int'(exp_diff) >= MAN_W + 3)
      s_al = {{(SW-1){1'b0}}, |s_ext};
    else
      s_al = (s_ext >> exp_diff) |
             {{(SW-1){1'b0}}, |(s_ext & ~({SW{1'b1}} << exp_diff))};

    spec = a_nan || b_nan || a_inf || b_inf;
    if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign)))
      spec_val = QNAN;
    else if (a_inf)
      spec_val = {a_sign, EXP_MAX, {MAN_W{1'b0}}};
    else
      spec_val = {b_sign, EXP_MAX, {MAN_W{1'b0}}};
  end

  logic             s1_valid, s1_sign, s1_sub, s1_spec;
  logic [EXP_W-1:0] s1_exp;
  logic [SW-1:0]    s1_ma, s1_mb;
  logic [W-1:0]     s1_spec_val;

  // S1 pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_sign     <= 1'b0;
      s1_sub      <= 1'b0;
      s1_spec     <= 1'b0;
      s1_exp      <= '0;
      s1_ma       <= '0;
      s1_mb       <= '0;
      s1_spec_val <= '0;
    end else if (advance) begin
      s1_valid    <= bus.in_valid;
      s1_sign     <= l_sign;
      s1_sub      <= a_sign ^ b_sign;
      s1_spec     <= spec;
      s1_exp      <= l_exp;
      s1_ma       <= {l_sig, 3'b000};
      s1_mb       <= s_al;
      s1_spec_val <= spec_val;
    end
  end

  // ---------------- S2: add/subtract + leading-zero count ----------------
  logic [SW:0]    mag;
  logic [LZW-1:0] lz;
  logic           lz_found, res_sign;

  // The larger operand is always A, so the difference never goes negative.
  always_comb begin
    mag      = s1_sub ? ({1'b0, s1_ma} - {1'b0, s1_mb}) : ({1'b0, s1_ma} + {1'b0, s1_mb});
    lz       = '0;
    lz_found = 1'b0;
    for (int i = SW - 1; i >= 0; i--) begin
      if (!lz_found && mag[i]) begin
        lz_found = 1'b1;
        lz       = LZW'(SW - 1 - i);
      end
    end
    res_sign = (s1_sub && (mag == '0)) ? 1'b0 : s1_sign;
  end

  logic             s2_valid, s2_sign, s2_spec;
  logic [EXP_W-1:0] s2_exp;
  logic [SW:0]      s2_mag;
  logic [LZW-1:0]   s2_lz;
  logic [W-1:0]     s2_spec_val;

  // S2 pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid    <= 1'b0;
      s2_sign     <= 1'b0;
      s2_spec     <= 1'b0;
      s2_exp      <= '0;
      s2_mag      <= '0;
      s2_lz       <= '0;
      s2_spec_val <= '0;
    end else if (advance) begin
      s2_valid    <= s1_valid;
      s2_sign     <= res_sign;
      s2_spec     <= s1_spec;
      s2_exp      <= s1_exp;
      s2_mag      <= mag;
      s2_lz       <= lz;
      s2_spec_val <= s1_spec_val;
    end
  end

  // ---------------- S3: normalise / round / pack ----------------
  logic [SW-1:0]    norm;
  logic [EW-1:0]    exp_n, exp_f;
  logic             rnd, lost;
  logic [MAN_W+1:0] man_r;
  logic [MAN_W-1:0] frac_f;
  logic [W-1:0]     res;
  logic             r_ovf, r_unf, r_inx;

  // Normalise, apply rounding, then resolve special, zero, underflow and overflow cases.
  always_comb begin
    if (s2_mag[SW]) begin
      norm  = s2_mag[SW:1] | {{(SW-1){1'b0}}, s2_mag[0]};
      exp_n = EW'(s2_exp) + EW'(1);
    end else begin
      norm  = s2_mag[SW-1:0] << s2_lz;
      exp_n = EW'(s2_exp) - EW'(s2_lz);
    end
    lost = |norm[2:0];
`ifdef FPALU_ADDSUB_RNE_EN
    rnd = norm[2] & (norm[1] | norm[0] | norm[3]);
`else
    rnd = 1'b0;
`endif
    man_r = {1'b0, norm[SW-1:3]} + {{(MAN_W+1){1'b0}}, rnd};
    if (man_r[MAN_W+1]) begin
      frac_f = man_r[MAN_W:1];
      exp_f  = exp_n + EW'(1);
    end else begin
      frac_f = man_r[MAN_W-1:0];
      exp_f  = exp_n;
    end

    res   = '0;
    r_ovf = 1'b0;
    r_unf = 1'b0;
    r_inx = 1'b0;
    if (s2_spec) begin
      res = s2_spec_val;
    end else if (s2_mag == '0) begin
      res = {s2_sign, {(W-1){1'b0}}};
    end else if (exp_n[EW-1] || (exp_n == '0)) begin
      res   = {s2_sign, {(W-1){1'b0}}};
      r_unf = 1'b1;
      r_inx = 1'b1;
    end else if (exp_f >= EW'(EXP_MAX)) begin
      res   = {s2_sign, EXP_MAX, {MAN_W{1'b0}}};
      r_ovf = 1'b1;
      r_inx = 1'b1;
    end else begin
      res   = {s2_sign, exp_f[EXP_W-1:0], frac_f};
      r_inx = lost;
    end
  end

  logic [W-1:0] sum_q;
  logic         ovf_q, unf_q, inx_q;

  // Output register; holds steady while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inx_q       <= 1'b0;
    end else if (advance) begin
      out_valid_q <= s2_valid;
      sum_q       <= res;
      ovf_q       <= r_ovf;
      unf_q       <= r_unf;
      inx_q       <= r_inx;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;
  assign bus.inx       = inx_q;

endmodule
